// File: rtl/restoring_div_34b_pkg.sv
// Shared types and sizing for the restoring divider.
// RESTORING_DIV_RADIX4_EN selects two restoring steps per clock.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_e;

    localparam int unsigned DIV_W = 34;

`ifdef RESTORING_DIV_RADIX4_EN
    localparam int unsigned DIV_STEPS = 2;
`else
    localparam int unsigned DIV_STEPS = 1;
`endif

    localparam int unsigned DIV_ITERS = DIV_W / DIV_STEPS;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_ITERS + 1);

endpackage

// File: rtl/restoring_div_34b_if.sv
// Start/done handshake bundle between a requester and the restoring divider.
interface restoring_div_34b_if #(
    parameter int unsigned W = div_pkg::DIV_W
);
    logic           start;
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           done;
    logic           busy;
    logic           dz;
    logic           ovf;

    modport master (
        output start, a, b,
        input  q, r, done, busy, dz, ovf
    );

    modport slave (
        input  start, a, b,
        output q, r, done, busy, dz, ovf
    );
endinterface

// File: rtl/restoring_div_34b_step.sv
// One combinational restoring-division step: shift in a dividend bit, try to subtract.
module div_step #(
    parameter int unsigned W = 34
) (
    input  logic [W-1:0] rem,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0]   w_shifted;
    logic         w_ge;
    logic [W-1:0] w_diff;

    // rem < divisor holds on entry, so a successful difference always fits in W bits
    always_comb begin
        w_shifted = {rem, in_bit};
        w_ge      = (w_shifted >= {1'b0, divisor});
        w_diff    = w_shifted[W-1:0] - divisor;
        q_bit     = w_ge;
        rem_next  = w_ge ? w_diff : w_shifted[W-1:0];
    end
endmodule

// File: rtl/restoring_div_34b.sv
// Iterative unsigned 2W/W restoring divider with start/done handshake.
// RESTORING_DIV_RADIX4_EN chains two div_step instances for W/2 iterations.
module restoring_div_34b
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic                clk,
    input  logic                rst_n,
    restoring_div_34b_if.slave  bus
);
    localparam int unsigned ITERS = W / DIV_STEPS;
    localparam int unsigned CNT_W = $clog2(ITERS + 1);

    div_state_e       r_state;
    div_state_e       w_state_next;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_shf;
    logic [W-1:0]     r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_q;
    logic [W-1:0]     r_r;
    logic             r_done;
    logic             r_dz;
    logic             r_ovf;

    logic [W-1:0]     w_a_hi;
    logic [W-1:0]     w_a_lo;
    logic             w_accept;
    logic             w_is_dz;
    logic             w_is_ovf;
    logic             w_last;
    logic [W-1:0]     w_rem1;
    logic             w_qb1;
    logic [W-1:0]     w_rem_fin;
    logic [W-1:0]     w_quo_next;
    logic [W-1:0]     w_shf_next;

    always_comb begin
        w_a_hi   = bus.a[2*W-1:W];
        w_a_lo   = bus.a[W-1:0];
        w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
        w_is_dz  = (bus.b == '0);
        w_is_ovf = !w_is_dz && (w_a_hi >= bus.b);
        w_last   = (r_cnt == CNT_W'(ITERS - 1));
    end

    div_step #(.W(W)) u_step0 (
        .rem      (r_rem),
        .in_bit   (r_shf[W-1]),
        .divisor  (r_b),
        .rem_next (w_rem1),
        .q_bit    (w_qb1)
    );

`ifdef RESTORING_DIV_RADIX4_EN
    logic [W-1:0] w_rem2;
    logic         w_qb2;

    div_step #(.W(W)) u_step1 (
        .rem      (w_rem1),
        .in_bit   (r_shf[W-2]),
        .divisor  (r_b),
        .rem_next (w_rem2),
        .q_bit    (w_qb2)
    );

    always_comb begin
        w_rem_fin  = w_rem2;
        w_quo_next = {r_quo[W-3:0], w_qb1, w_qb2};
        w_shf_next = {r_shf[W-3:0], 2'b00};
    end
`else
    always_comb begin
        w_rem_fin  = w_rem1;
        w_quo_next = {r_quo[W-2:0], w_qb1};
        w_shf_next = {r_shf[W-2:0], 1'b0};
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_next = (w_is_dz || w_is_ovf) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_b    <= '0;
            r_rem  <= '0;
            r_shf  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_ovf  <= 1'b0;
            if (w_is_dz) begin
                r_q    <= '1;
                r_r    <= w_a_lo;
                r_dz   <= 1'b1;
                r_done <= 1'b1;
            end else if (w_is_ovf) begin
                r_q    <= '1;
                r_r    <= '0;
                r_ovf  <= 1'b1;
                r_done <= 1'b1;
            end else begin
                r_b   <= bus.b;
                r_rem <= w_a_hi;
                r_shf <= w_a_lo;
                r_quo <= '0;
                r_cnt <= '0;
            end
        end else if (r_state == BUSY) begin
            r_rem <= w_rem_fin;
            r_shf <= w_shf_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_q    <= w_quo_next;
                r_r    <= w_rem_fin;
                r_done <= 1'b1;
                r_dz   <= 1'b0;
                r_ovf  <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.q    = r_q;
        bus.r    = r_r;
        bus.done = r_done;
        bus.busy = (r_state == BUSY);
        bus.dz   = r_dz;
        bus.ovf  = r_ovf;
    end
endmodule

// File: tb/tb_restoring_div_34b.sv
// Directed and random checks for restoring_div_34b (radix-2 or RESTORING_DIV_RADIX4_EN).
module tb_restoring_div_34b;
`ifdef RESTORING_DIV_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 34;
`endif
    localparam logic [33:0] ONES = '1;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    restoring_div_34b_if #(.W(34)) dif ();

    restoring_div_34b #(.W(34)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns edges after E0 until done is first seen (0 on timeout) and busy samples before that.
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = dif.busy ? 1 : 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (dif.done) begin
                cyc = k;
                break;
            end
            if (dif.busy) nbusy++;
        end
    endtask

    task automatic run_op(input string tag, input logic [67:0] ta, input logic [33:0] tb_,
                          input logic [33:0] eq, input logic [33:0] er,
                          input logic edz, input logic eovf, input int elat);
        int cyc;
        int nbusy;
        @(negedge clk);
        dif.start = 1'b1;
        dif.a     = ta;
        dif.b     = tb_;
        @(posedge clk); #1;
        dif.start = 1'b0;
        wait_done(cyc, nbusy);
        chk({tag, "_lat"}, 68'(cyc), 68'(elat));
        chk({tag, "_busy"}, 68'(nbusy), (edz || eovf) ? 68'd0 : 68'(elat));
        chk({tag, "_q"}, 68'(dif.q), 68'(eq));
        chk({tag, "_r"}, 68'(dif.r), 68'(er));
        chk({tag, "_dz"}, 68'(dif.dz), 68'(edz));
        chk({tag, "_ovf"}, 68'(dif.ovf), 68'(eovf));
        @(posedge clk); #1;
        chk({tag, "_hold"}, {33'd0, dif.done, dif.q}, {33'd0, 1'b1, eq});
    endtask

    initial begin
        logic [33:0] x, y, z, rz;
        logic [67:0] pa;
        int cyc, nbusy;

        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {dif.q, dif.r}, 68'd0);
        chk("rst_flags", 68'({dif.done, dif.busy, dif.dz, dif.ovf}), 68'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", 68'd100, 34'd7, 34'd14, 34'd2, 1'b0, 1'b0, LAT);
        run_op("maxsq", 68'hF_FFFF_FFF8_0000_0001, ONES, ONES, 34'd0, 1'b0, 1'b0, LAT);
        pa = {34'd0, 34'h2_ABCD_1234} * {34'd0, 34'h1_0000_0003} + 68'd5;
        run_op("karat", pa, 34'h1_0000_0003, 34'h2_ABCD_1234, 34'd5, 1'b0, 1'b0, LAT);
        pa = {34'd0, 34'h2_ABCD_1234} * {34'd0, 34'h1_0000_0003};
        run_op("inv", pa, 34'h2_ABCD_1234, 34'h1_0000_0003, 34'd0, 1'b0, 1'b0, LAT);
        run_op("dz", 68'd5, 34'd0, ONES, 34'd5, 1'b1, 1'b0, 1);
        run_op("ovf", 68'h4_0000_0000_0, 34'd1, ONES, 34'd0, 1'b0, 1'b1, 1);

        // second start mid-operation is ignored
        @(negedge clk);
        dif.start = 1'b1; dif.a = 68'd100; dif.b = 34'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        dif.start = 1'b1; dif.a = 68'd1000; dif.b = 34'd3;
        @(posedge clk); #1;
        dif.start = 1'b0;
        wait_done(cyc, nbusy);
        chk("ign_lat", 68'(cyc), 68'(LAT - 10));
        chk("ign_qr", {dif.q, dif.r}, {34'd14, 34'd2});

        // start held two cycles runs a single operation
        @(negedge clk);
        dif.start = 1'b1; dif.a = 68'd100; dif.b = 34'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        wait_done(cyc, nbusy);
        chk("hold2_lat", 68'(cyc), 68'(LAT - 1));
        repeat (3) @(posedge clk);
        #1;
        chk("hold2_idle", 68'({dif.done, dif.busy}), 68'b10);

        // start held through DONE restarts at once
        @(negedge clk);
        dif.start = 1'b1; dif.a = 68'd100; dif.b = 34'd7;
        @(posedge clk); #1;
        dif.a = 68'd1000; dif.b = 34'd3;
        wait_done(cyc, nbusy);
        chk("b2b_first", 68'(dif.q), 68'd14);
        @(posedge clk); #1;
        dif.start = 1'b0;
        chk("b2b_restart", 68'({dif.done, dif.busy}), 68'b01);
        wait_done(cyc, nbusy);
        chk("b2b_second", {dif.q, dif.r}, {34'd333, 34'd1});

        // reset mid-operation
        @(negedge clk);
        dif.start = 1'b1; dif.a = 68'd1000; dif.b = 34'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_outs", {dif.q, dif.r}, 68'd0);
        chk("midrst_flags", 68'({dif.done, dif.busy, dif.dz, dif.ovf}), 68'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("postrst", 68'd1000, 34'd7, 34'd142, 34'd6, 1'b0, 1'b0, LAT);

        for (int i = 0; i < 200; i++) begin
            x  = 34'({$urandom(), $urandom()});
            y  = 34'({$urandom(), $urandom()});
            if (y == '0) y = 34'd1;
            rz = 34'({$urandom(), $urandom()});
            z  = rz % y;
            pa = {34'd0, x} * {34'd0, y} + {34'd0, z};
            run_op("rand", pa, y, x, z, 1'b0, 1'b0, LAT);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
